// File: rtl/maxpool_pkg.sv
// Shared types and helpers for the max-pooling stage.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package maxpool_pkg;

  // Per-pixel handshake FSM of the pooling stage
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPUTE    = 2'd1,
    EMIT_WE    = 2'd2,
    EMIT_START = 2'd3
  } state_t;

  // Output side of a non-overlapping pool: partial windows at the edge are dropped
  function automatic int calc_out_dim(input int in_dim, input int pool_dim);
    return in_dim / pool_dim;
  endfunction

  // Index width for a counter spanning 0..n-1, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row buffer of running window maxima, one entry per output column.
// Latency: combinational read, write lands on the next clock edge.
// Backpressure: none; the owner decides when to write.
module pool_line_buf
  import maxpool_pkg::*;
#(
  parameter int DEPTH     = 13,
  parameter int CHANNELS  = 4,
  parameter int DATA_SIZE = 8,
  parameter int AW        = idx_width(DEPTH)
) (
  input  logic                                clk,
  input  logic                                we,
  input  logic [AW-1:0]                       idx,
  input  logic [CHANNELS-1:0][DATA_SIZE-1:0]  wdata,
  output logic [CHANNELS-1:0][DATA_SIZE-1:0]  rdata
);

  // Contents are deliberately not reset: the first pixel of every window overwrites its entry
  logic [CHANNELS-1:0][DATA_SIZE-1:0] mem [DEPTH];

  assign rdata = mem[idx];

  // Single synchronous write port at the same index as the read
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

endmodule

// File: rtl/maxpool_layer.sv
// Non-overlapping POOL_DIM x POOL_DIM max pool over a raster stream of multi-channel pixels.
// Latency: i_start at t -> o_next_we at t+2, o_next_start at t+3, o_ready back at t+4 (t+2 if no emit).
// Backpressure: holds in EMIT_WE with o_ready low until i_next_ready; extra i_start pulses are dropped.
module maxpool_layer
  import maxpool_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int IN_DIM    = 26,
  parameter int CHANNELS  = 4,
  parameter int POOL_DIM  = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNELS-1:0]                 i_we,
  input  logic [CHANNELS-1:0][DATA_SIZE-1:0]  i_data,
  input  logic                                i_start,
  output logic                                o_ready,
  input  logic                                i_next_ready,
  output logic [CHANNELS-1:0][DATA_SIZE-1:0]  o_next_data,
  output logic [CHANNELS-1:0]                 o_next_we,
  output logic                                o_next_start
);

  localparam int OUT_DIM = calc_out_dim(IN_DIM, POOL_DIM);
  localparam int USED    = OUT_DIM * POOL_DIM;
  localparam int PW      = idx_width(IN_DIM);
  localparam int WW      = idx_width(POOL_DIM);
  localparam int JW      = idx_width(OUT_DIM);

  state_t state;
  state_t state_nxt;

  logic [CHANNELS-1:0][DATA_SIZE-1:0] pix;
  logic [CHANNELS-1:0][DATA_SIZE-1:0] lb_rd;
  logic [CHANNELS-1:0][DATA_SIZE-1:0] lb_wdata;
  logic [CHANNELS-1:0][DATA_SIZE-1:0] pooled;

  logic [PW-1:0] row;
  logic [PW-1:0] col;
  logic [WW-1:0] wr;
  logic [WW-1:0] wc;
  logic [JW-1:0] j;

  logic drop;
  logic win_first;
  logic win_last;
  logic lb_we;

  // Pixels in the ragged right/bottom strip never belong to a full window
  assign drop      = (int'(row) >= USED) || (int'(col) >= USED);
  assign win_first = (wr == '0) && (wc == '0);
  assign win_last  = !drop && (int'(wr) == POOL_DIM - 1) && (int'(wc) == POOL_DIM - 1);
  assign lb_we     = (state == COMPUTE) && !drop;

  // Pixel register: channels load independently, only while the stage is accepting
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (o_ready && i_we[c]) begin
        pix[c] <= i_data[c];
      end
    end
  end

  // Per-channel unsigned max of the stored partial window and the current pixel
  always_comb begin
    pooled = pix;
    for (int c = 0; c < CHANNELS; c++) begin
      if (lb_rd[c] > pix[c]) begin
        pooled[c] = lb_rd[c];
      end
    end
  end

  // First pixel of a window restarts the running max instead of merging with stale data
  always_comb begin
    lb_wdata = win_first ? pix : pooled;
  end

  pool_line_buf #(
    .DEPTH     (OUT_DIM),
    .CHANNELS  (CHANNELS),
    .DATA_SIZE (DATA_SIZE),
    .AW        (JW)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .idx   (j),
    .wdata (lb_wdata),
    .rdata (lb_rd)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; o_next_we is gated by i_next_ready in the same cycle
  always_comb begin
    state_nxt    = state;
    o_ready      = 1'b0;
    o_next_we    = '0;
    o_next_start = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        state_nxt = win_last ? EMIT_WE : IDLE;
      end
      EMIT_WE: begin
        if (i_next_ready) begin
          o_next_we = '1;
          state_nxt = EMIT_START;
        end
      end
      EMIT_START: begin
        o_next_start = 1'b1;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pooled result is captured once per window and held until the next window completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_next_data <= '0;
    end else if ((state == COMPUTE) && win_last) begin
      o_next_data <= pooled;
    end
  end

  // Raster position and window sub-indices; j steps once per POOL_DIM columns, no divider
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
      wr  <= '0;
      wc  <= '0;
      j   <= '0;
    end else if (state == COMPUTE) begin
      if (int'(col) == IN_DIM - 1) begin
        col <= '0;
        wc  <= '0;
        j   <= '0;
        if (int'(row) == IN_DIM - 1) begin
          row <= '0;
          wr  <= '0;
        end else begin
          row <= row + 1'b1;
          wr  <= (int'(wr) == POOL_DIM - 1) ? '0 : wr + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
        if (int'(wc) == POOL_DIM - 1) begin
          wc <= '0;
          // Wraps early in the dropped strip so j always stays a valid buffer index
          j  <= (int'(j) == OUT_DIM - 1) ? '0 : j + 1'b1;
        end else begin
          wc <= wc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_layer.sv
// Directed bench for maxpool_layer: a 4x4 instance for protocol scenarios, a 5x5 instance for edge dropping.
// Latency: n/a.
// Backpressure: driven explicitly per scenario through the next_ready inputs.
module tb_maxpool_layer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 4x4 instance
  logic [1:0]      a_we;
  logic [1:0][7:0] a_data;
  logic            a_start;
  logic            a_ready;
  logic            a_next_ready;
  logic [1:0][7:0] a_next_data;
  logic [1:0]      a_next_we;
  logic            a_next_start;

  // 5x5 instance
  logic [1:0]      b_we;
  logic [1:0][7:0] b_data;
  logic            b_start;
  logic            b_ready;
  logic            b_next_ready;
  logic [1:0][7:0] b_next_data;
  logic [1:0]      b_next_we;
  logic            b_next_start;

  maxpool_layer #(.DATA_SIZE(8), .IN_DIM(4), .CHANNELS(2), .POOL_DIM(2)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .i_we         (a_we),
    .i_data       (a_data),
    .i_start      (a_start),
    .o_ready      (a_ready),
    .i_next_ready (a_next_ready),
    .o_next_data  (a_next_data),
    .o_next_we    (a_next_we),
    .o_next_start (a_next_start)
  );

  maxpool_layer #(.DATA_SIZE(8), .IN_DIM(5), .CHANNELS(2), .POOL_DIM(2)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .i_we         (b_we),
    .i_data       (b_data),
    .i_start      (b_start),
    .o_ready      (b_ready),
    .i_next_ready (b_next_ready),
    .o_next_data  (b_next_data),
    .o_next_we    (b_next_we),
    .o_next_start (b_next_start)
  );

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] qa[$];
  logic [1:0]  qa_we[$];
  int          qa_wcyc[$];
  int          qa_scyc[$];
  logic [15:0] qb[$];
  bit          a_bad_we;

  // Hand-computed window maxima for the 4x4 ramp frame (ch0 = 0..15, ch1 = 15..0)
  logic [7:0] exp0 [4] = '{8'd5, 8'd7, 8'd13, 8'd15};
  logic [7:0] exp1 [4] = '{8'd15, 8'd13, 8'd7, 8'd5};
  // 5x5 frame: valid region holds r*5+c on ch0 and 100+r*5+c on ch1, row/col 4 hold 255
  logic [7:0] bexp0 [4] = '{8'd6, 8'd8, 8'd16, 8'd18};
  logic [7:0] bexp1 [4] = '{8'd106, 8'd108, 8'd116, 8'd118};

  always @(posedge clk) cyc <= cyc + 1;

  // Output capture on the falling edge
  always @(negedge clk) begin
    if (a_next_we != 2'b00) begin
      qa.push_back(a_next_data);
      qa_we.push_back(a_next_we);
      qa_wcyc.push_back(cyc);
      if (!a_next_ready) a_bad_we = 1'b1;
    end
    if (a_next_start) qa_scyc.push_back(cyc);
    if (b_next_we != 2'b00) qb.push_back(b_next_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    qa.delete();
    qa_we.delete();
    qa_wcyc.delete();
    qa_scyc.delete();
    qb.delete();
    a_bad_we = 1'b0;
  endtask

  // Present one pixel with i_start once ready; returns one cycle after the accepting edge
  task automatic send_a(input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] we);
    int n = 0;
    while (a_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      tests++;
      errors++;
      $display("FAIL send_a_ready_timeout got ready=%b want 1", a_ready);
    end
    a_we      = we;
    a_data[0] = d0;
    a_data[1] = d1;
    a_start   = 1'b1;
    tick();
    a_we    = 2'b00;
    a_start = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d0, input logic [7:0] d1);
    int n = 0;
    while (b_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      tests++;
      errors++;
      $display("FAIL send_b_ready_timeout got ready=%b want 1", b_ready);
    end
    b_we      = 2'b11;
    b_data[0] = d0;
    b_data[1] = d1;
    b_start   = 1'b1;
    tick();
    b_we    = 2'b00;
    b_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    tests++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", a_ready); end
    tests++; if (a_next_we !== 2'b00) begin errors++; $display("FAIL reset_we got %b want 00", a_next_we); end
    tests++; if (a_next_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", a_next_start); end
    tests++; if (a_next_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", a_next_data); end
    tests++; if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ready got %b want 1", b_ready); end
  endtask

  task automatic test_basic();
    clear_q();
    a_next_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      send_a(8'(k), 8'(15 - k), 2'b11);
      if (k == 0) begin
        tests++; if (a_ready !== 1'b0) begin errors++; $display("FAIL plain_t1_ready got %b want 0", a_ready); end
        tick();
        tests++; if (a_ready !== 1'b1) begin errors++; $display("FAIL plain_t2_ready got %b want 1", a_ready); end
      end
      if (k == 5) begin
        tests++; if (a_ready !== 1'b0) begin errors++; $display("FAIL emit_t1_ready got %b want 0", a_ready); end
        tick();
        tests++; if (a_next_we !== 2'b11) begin errors++; $display("FAIL emit_t2_we got %b want 11", a_next_we); end
        tests++; if (a_next_data !== {8'd15, 8'd5}) begin errors++; $display("FAIL emit_t2_data got %h want 0f05", a_next_data); end
        tick();
        tests++; if (a_next_start !== 1'b1 || a_next_we !== 2'b00) begin errors++; $display("FAIL emit_t3_start got start=%b we=%b want 1/00", a_next_start, a_next_we); end
        tick();
        tests++; if (a_ready !== 1'b1) begin errors++; $display("FAIL emit_t4_ready got %b want 1", a_ready); end
      end
    end
    repeat (8) tick();
    tests++; if (qa.size() != 4 || qa_scyc.size() != 4) begin errors++; $display("FAIL basic_count got we=%0d start=%0d want 4/4", qa.size(), qa_scyc.size()); end
    for (int k = 0; k < 4 && k < qa.size(); k++) begin
      tests++; if (qa[k] !== {exp1[k], exp0[k]}) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", k, qa[k], {exp1[k], exp0[k]}); end
      tests++; if (qa_we[k] !== 2'b11) begin errors++; $display("FAIL basic_we[%0d] got %b want 11", k, qa_we[k]); end
      if (k < qa_scyc.size()) begin
        tests++; if (qa_scyc[k] != qa_wcyc[k] + 1) begin errors++; $display("FAIL basic_start_follow[%0d] got cyc %0d want %0d", k, qa_scyc[k], qa_wcyc[k] + 1); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit held_bad = 1'b0;
    clear_q();
    a_next_ready = 1'b0;
    for (int k = 0; k < 6; k++) send_a(8'(k), 8'(15 - k), 2'b11);
    for (int i = 0; i < 11; i++) begin
      if (a_next_we !== 2'b00 || a_ready !== 1'b0) held_bad = 1'b1;
      tick();
    end
    tests++; if (held_bad) begin errors++; $display("FAIL bp_hold got we/ready active while stalled want we=00 ready=0"); end
    a_next_ready = 1'b1;
    #1;
    tests++; if (a_next_we !== 2'b11) begin errors++; $display("FAIL bp_release_we got %b want 11", a_next_we); end
    tests++; if (a_next_data !== {8'd15, 8'd5}) begin errors++; $display("FAIL bp_release_data got %h want 0f05", a_next_data); end
    tick();
    tests++; if (a_next_start !== 1'b1) begin errors++; $display("FAIL bp_start got %b want 1", a_next_start); end
    for (int k = 6; k < 16; k++) send_a(8'(k), 8'(15 - k), 2'b11);
    repeat (8) tick();
    tests++; if (qa.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", qa.size()); end
    if (qa.size() > 0) begin
      tests++; if (qa[0] !== {8'd15, 8'd5}) begin errors++; $display("FAIL bp_first got %h want 0f05", qa[0]); end
    end
    tests++; if (a_bad_we) begin errors++; $display("FAIL bp_we_without_ready got 1 want 0"); end
  endtask

  task automatic test_ignored_start();
    clear_q();
    a_next_ready = 1'b1;
    for (int k = 0; k < 5; k++) send_a(8'(k), 8'(15 - k), 2'b11);
    send_a(8'd5, 8'd10, 2'b11);
    // Junk start/write for two cycles while the window-final pixel is still in flight
    a_start   = 1'b1;
    a_we      = 2'b11;
    a_data[0] = 8'd250;
    a_data[1] = 8'd250;
    tick();
    tick();
    a_start = 1'b0;
    a_we    = 2'b00;
    // Start without writes: the register must still hold pixel 5 (5,10)
    send_a(8'd200, 8'd200, 2'b00);
    for (int k = 7; k < 16; k++) send_a(8'(k), 8'(15 - k), 2'b11);
    repeat (8) tick();
    tests++; if (qa.size() != 4) begin errors++; $display("FAIL ign_count got %0d want 4", qa.size()); end
    for (int k = 0; k < 4 && k < qa.size(); k++) begin
      tests++; if (qa[k] !== {exp1[k], exp0[k]}) begin errors++; $display("FAIL ign_data[%0d] got %h want %h", k, qa[k], {exp1[k], exp0[k]}); end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    a_next_ready = 1'b0;
    for (int k = 0; k < 6; k++) send_a(8'(k), 8'(15 - k), 2'b11);
    repeat (3) tick();
    a_next_ready = 1'b1;
    rst = 1'b0;
    #1;
    tests++; if (a_next_we !== 2'b00) begin errors++; $display("FAIL rstmid_we got %b want 00", a_next_we); end
    tests++; if (a_next_start !== 1'b0) begin errors++; $display("FAIL rstmid_start got %b want 0", a_next_start); end
    tests++; if (a_next_data !== 16'h0000) begin errors++; $display("FAIL rstmid_data got %h want 0000", a_next_data); end
    tests++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", a_ready); end
    tick();
    rst = 1'b1;
    tick();
    clear_q();
    for (int k = 0; k < 16; k++) send_a(8'(k), 8'(15 - k), 2'b11);
    repeat (8) tick();
    tests++; if (qa.size() != 4) begin errors++; $display("FAIL rstmid_count got %0d want 4", qa.size()); end
    for (int k = 0; k < 4 && k < qa.size(); k++) begin
      tests++; if (qa[k] !== {exp1[k], exp0[k]}) begin errors++; $display("FAIL rstmid_data[%0d] got %h want %h", k, qa[k], {exp1[k], exp0[k]}); end
    end
  endtask

  task automatic test_unsigned();
    logic [7:0] v;
    clear_q();
    a_next_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      case (k)
        0:       v = 8'd255;
        1:       v = 8'd0;
        4:       v = 8'd128;
        5:       v = 8'd1;
        default: v = 8'd0;
      endcase
      send_a(v, 8'd0, 2'b11);
    end
    repeat (8) tick();
    tests++; if (qa.size() != 4) begin errors++; $display("FAIL uns_count got %0d want 4", qa.size()); end
    if (qa.size() > 1) begin
      tests++; if (qa[0] !== {8'd0, 8'd255}) begin errors++; $display("FAIL uns_max got %h want 00ff", qa[0]); end
      tests++; if (qa[1] !== 16'h0000) begin errors++; $display("FAIL uns_second got %h want 0000", qa[1]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    clear_q();
    b_next_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          v = (r < 4 && c < 4) ? 8'(r * 5 + c) : 8'd255;
          send_b(v, (v == 8'd255) ? 8'd255 : v + 8'd100);
        end
      end
    end
    repeat (8) tick();
    tests++; if (qb.size() != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", qb.size()); end
    for (int k = 0; k < 8 && k < qb.size(); k++) begin
      tests++; if (qb[k] !== {bexp1[k % 4], bexp0[k % 4]}) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", k, qb[k], {bexp1[k % 4], bexp0[k % 4]}); end
    end
  endtask

  initial begin
    rst          = 1'b0;
    a_we         = 2'b00;
    a_data       = '0;
    a_start      = 1'b0;
    a_next_ready = 1'b1;
    b_we         = 2'b00;
    b_data       = '0;
    b_start      = 1'b0;
    b_next_ready = 1'b1;
    a_bad_we     = 1'b0;

    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_start();
    test_reset_mid();
    test_unsigned();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/maxpool_layer.md
# maxpool_layer

Non-overlapping POOL_DIM×POOL_DIM max-pooling stage that sits directly downstream of the convolution layer. It accepts one output pixel, which is all channels, per upstream `start` handshake, in raster order. It keeps running per-window maxima in a one-row line buffer. Each completed pooled pixel is emitted using the same write-enable/start/ready protocol the conv layer drives, so the next layer sees an identical interface.

## Interface
Parameters:
- DATA_SIZE, 8, bits per element; elements are unsigned (post-activation).
- IN_DIM, 26, input feature-map side in pixels.
- CHANNELS, 4, channels per pixel.
- POOL_DIM, 2, window side and stride.
- OUT_DIM (derived), IN_DIM/POOL_DIM floored, output side.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, asynchronous, active-low.
- i_we  in  CHANNELS  per-channel write enable for the pixel register.
- i_data  in  DATA_SIZE×[CHANNELS]  per-channel pixel data.
- i_start  in  1  pixel complete; consume the pixel register.
- o_ready  out  1  block can accept writes and i_start.
- i_next_ready  in  1  downstream can accept a pooled pixel.
- o_next_data  out  DATA_SIZE×[CHANNELS]  pooled pixel, registered.
- o_next_we  out  CHANNELS  downstream write enable, all bits pulse together.
- o_next_start  out  1  one-cycle pulse after o_next_we.

## Operation
- **Pixel register:** while o_ready=1, i_we[c] loads i_data[c] into channel c. i_we is ignored while o_ready=0.
- **Position tracking:** counters track row and col (0..IN_DIM-1) and window sub-indices wr, wc (0..POOL_DIM-1). The window column index j is kept as its own counter; no divider.
- **Dropped pixels:** if row or col ≥ OUT_DIM·POOL_DIM, the pixel is accepted, the counters advance, and there is no buffer access and no output.
- **Buffer update:**
  - First pixel of a window (wr=0, wc=0): lb[j] ← pixel.
  - Any other pixel: lb[j] ← per-channel unsigned max(lb[j], pixel).
- **Emit:** the last pixel of a window (wr=wc=POOL_DIM-1) loads o_next_data ← max(lb[j], pixel) and emits it.
- **Frame wrap:** after (IN_DIM-1, IN_DIM-1) all counters wrap to 0 and the next frame begins. There is no frame-level signal.
- **FSM states:**
  - IDLE: o_ready=1. On i_start, go to COMPUTE.
  - COMPUTE: read-modify-write of lb, counter advance. Go to EMIT_WE if the pixel is window-final, else to IDLE.
  - EMIT_WE: wait for i_next_ready=1. In that cycle, o_next_we = all ones, then go to EMIT_START.
  - EMIT_START: o_next_start=1, then go to IDLE.
- **Ignored inputs:** i_start while o_ready=0 is ignored and does not queue.

## Timing
- **Reset values:** o_ready=1 (IDLE), o_next_we=0, o_next_start=0, o_next_data=0, counters=0. Pixel register and lb are not reset; the first-of-window write overwrites them.
- **Reset mid-operation:** outputs go to the reset values immediately. Any pending emit is lost, and the frame restarts at (0,0).
- **i_start sampled at cycle t:**
  - o_ready=0 at t+1.
  - i_we at t is included in that pixel.
- **Non-emitting pixel:** o_ready=1 again at t+2.
- **Emitting pixel with i_next_ready=1:** o_next_we at t+2, o_next_start at t+3, o_ready=1 at t+4.
- **Backpressure:** each cycle i_next_ready=0 in EMIT_WE adds one cycle. o_next_we is never asserted while i_next_ready=0.
- **Output hold:** o_next_data is stable from t+2 until the next emission's COMPUTE cycle.
- **Throughput:** at most one pixel per 2 cycles.

## Structure
- Package `maxpool_pkg`: FSM state enum (IDLE, COMPUTE, EMIT_WE, EMIT_START) and the OUT_DIM derivation function.
- Sub-module `pool_line_buf`: OUT_DIM × CHANNELS × DATA_SIZE register array with one combinational read port and one synchronous write port, indexed by j.
- Top level: pixel register, counters, FSM, max comparators.

## Test plan
- IN_DIM=4, CHANNELS=2, POOL_DIM=2; ch0 = 0..15 raster, ch1 = 15..0 raster, i_next_ready=1 -> outputs in order: ch0 {5,7,13,15}, ch1 {15,13,7,5}. Each output has o_next_we=2'b11 followed one cycle later by o_next_start.
- Same frame, i_next_ready low for 10 cycles at the first emit -> o_next_we stays 0 and o_ready stays 0. A single emission of 5/15 occurs in the cycle i_next_ready rises, and o_next_start follows one cycle later.
- IN_DIM=5, two back-to-back frames of 25 pixels each -> 4 outputs per frame. Row 4 and col 4 pixels (values 255) never appear in any output, and the second frame's results match the first.
- Pulse i_start at t+1 and t+2 after an accepted i_start -> both ignored. Counters advance by exactly one, and i_we during o_ready=0 does not alter the pixel register.
- Assert rst in EMIT_WE -> o_next_we, o_next_start and o_next_data read 0 in the same cycle, and o_ready=1. The following 16-pixel frame gives the outputs of the first scenario.
- One window of values {255, 0, 128, 1} on ch0 -> output 255, checking the unsigned compare.
